// File: rtl/alu_share_ctrl.sv
// -----------------------------------------------------------------------------
// alu_share_ctrl
//
// Shares one ALU (add, sub, or, and) among NUM_REQ requesters. A round-robin
// arbiter grants one request at a time. The granted request is sequenced
// IDLE -> EXEC -> RESP, and its result is returned on a registered response
// port tagged with the owning requester's ID.
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   WIDTH    operand/result width
//   ID_W     requester ID width, ceil(log2(NUM_REQ)), minimum 1
//
// Ports:
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   req_valid  per-requester request valid               [NUM_REQ]
//   req_ready  per-requester accept, one-hot or zero     [NUM_REQ] (comb)
//   req_op     opcode of requester i at [2i+1:2i]        [2*NUM_REQ]
//              (00 add, 01 sub, 10 or, 11 and)
//   req_a      operand A of requester i at [WIDTH*i +: WIDTH]
//   req_b      operand B, same packing
//   rsp_valid  result available (registered)
//   rsp_ready  consumer accepts result
//   rsp_id     requester that owns rsp_data (registered)
//   rsp_data   ALU result (registered)
//   busy       high while in EXEC or RESP (registered)
//   op_count   completed-operation counter
//
// Optional feature macro: ALU_SHARE_CTRL_STATS_EN
//   Defined   : op_count counts response handshakes and saturates at 16'hFFFF.
//   Undefined : no counter is built and op_count is tied to zero.
// -----------------------------------------------------------------------------
module alu_share_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 64,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [WIDTH*NUM_REQ-1:0] req_a,
    input  logic [WIDTH*NUM_REQ-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     busy,
    output logic [15:0]              op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   cur_id;
    logic [ID_W-1:0]   grant_id;
    logic              grant_found;

    logic [1:0]        sel_op;
    logic [WIDTH-1:0]  sel_a;
    logic [WIDTH-1:0]  sel_b;

    logic [1:0]        op_p0;
    logic [WIDTH-1:0]  a_p0;
    logic [WIDTH-1:0]  b_p0;

    // Add/sub wrap modulo 2^WIDTH; no flags are produced.
    function automatic logic [WIDTH-1:0] alu_calc(
        input logic [1:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (op)
            2'b00:   r = a + b;
            2'b01:   r = a - b;
            2'b10:   r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_found) next_state = EXEC;
            EXEC:    next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output logic: round-robin grant. The search starts at rr_ptr and wraps,
    // so the requester just served has the lowest priority next time.
    always_comb begin
        int idx;
        idx         = 0;
        req_ready   = '0;
        grant_id    = '0;
        grant_found = 1'b0;
        if (rst_n && state == IDLE) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                if (!grant_found && req_valid[ID_W'(idx)]) begin
                    grant_found = 1'b1;
                    grant_id    = ID_W'(idx);
                end
            end
            if (grant_found) begin
                req_ready[grant_id] = 1'b1;
            end
        end
    end

    // Operand mux for the granted requester
    always_comb begin
        sel_op = '0;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                sel_op = req_op[2*i +: 2];
                sel_a  = req_a[WIDTH*i +: WIDTH];
                sel_b  = req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    // ---- p0: operands captured on the request handshake ----
    always_ff @(posedge clk) begin
        if (grant_found) begin
            op_p0 <= sel_op;
            a_p0  <= sel_a;
            b_p0  <= sel_b;
        end
    end

    // ---- p1: ALU result registered in EXEC, held through RESP ----
    // rsp_valid and busy are registered from next_state so they are clean
    // flop outputs aligned with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            cur_id    <= '0;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= (next_state == RESP);
            busy      <= (next_state != IDLE);
            if (grant_found) begin
                cur_id <= grant_id;
                rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
            end
            if (state == EXEC) begin
                rsp_data <= alu_calc(op_p0, a_p0, b_p0);
                rsp_id   <= cur_id;
            end
        end
    end

`ifdef ALU_SHARE_CTRL_STATS_EN
    logic [15:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 16'h0000;
        end else if (rsp_valid && rsp_ready && count != 16'hFFFF) begin
            count <= count + 16'd1;
        end
    end

    assign op_count = count;
`else
    assign op_count = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
module tb_alu_share_ctrl;

    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 64;
    localparam int ID_W    = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [2*NUM_REQ-1:0]     req_op;
    logic [WIDTH*NUM_REQ-1:0] req_a;
    logic [WIDTH*NUM_REQ-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [WIDTH-1:0]         rsp_data;
    logic                     busy;
    logic [15:0]              op_count;

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;

    alu_share_ctrl #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    // Reference count of response handshakes, cleared by reset
    always @(posedge clk) begin
        if (!rst_n) hs_cnt <= 0;
        else if (rsp_valid === 1'b1 && rsp_ready === 1'b1) hs_cnt <= hs_cnt + 1;
    end

    typedef struct {
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        int          id;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_count();
`ifdef ALU_SHARE_CTRL_STATS_EN
        return 16'(hs_cnt);
`else
        return 16'h0000;
`endif
    endfunction

    task automatic run_vec(input int n, input vec_t v);
        logic [3:0] exp_rdy;
        exp_rdy = 4'b0001 << v.id;
        req_valid = exp_rdy;
        req_op[2*v.id +: 2]   = v.op;
        req_a[64*v.id +: 64]  = v.a;
        req_b[64*v.id +: 64]  = v.b;
        #1;
        chk($sformatf("vec%0d_grant", n), 64'(req_ready), 64'(exp_rdy));
        step();
        // Corrupt the slot after accept: the latched operands must be used
        req_valid = '0;
        req_op[2*v.id +: 2]  = ~v.op;
        req_a[64*v.id +: 64] = {$urandom, $urandom};
        req_b[64*v.id +: 64] = {$urandom, $urandom};
        #1;
        chk($sformatf("vec%0d_exec_busy", n), 64'(busy), 64'd1);
        chk($sformatf("vec%0d_exec_valid", n), 64'(rsp_valid), 64'd0);
        step();
        chk($sformatf("vec%0d_rsp_valid", n), 64'(rsp_valid), 64'd1);
        chk($sformatf("vec%0d_rsp_id", n), 64'(rsp_id), 64'(v.id));
        chk($sformatf("vec%0d_rsp_data", n), rsp_data, v.exp);
        chk($sformatf("vec%0d_rsp_busy", n), 64'(busy), 64'd1);
        step();
        chk($sformatf("vec%0d_idle_valid", n), 64'(rsp_valid), 64'd0);
        chk($sformatf("vec%0d_idle_busy", n), 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gid[8];
        int gcyc[8];
        int rid[8];
        logic [63:0] rdat[8];
        int ng;
        int nr;

        vecs[0] = '{2'b00, 64'd5, 64'd3, 2, 64'd8};
        vecs[1] = '{2'b01, 64'd0, 64'd1, 1, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[2] = '{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 3, 64'd1};
        vecs[3] = '{2'b10, 64'hF0, 64'h0F, 0, 64'hFF};
        vecs[4] = '{2'b11, 64'hF0, 64'h3C, 2, 64'h30};
        vecs[5] = '{2'b01, 64'd10, 64'd3, 1, 64'd7};
        vecs[6] = '{2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0123_4567_89AB_CDEF, 0, 64'h0123_4567_89AB_CDEF};
        vecs[7] = '{2'b10, 64'h8000_0000_0000_0000, 64'd1, 3, 64'h8000_0000_0000_0001};
        vecs[8] = '{2'b01, 64'd3, 64'd5, 2, 64'hFFFF_FFFF_FFFF_FFFE};

        // Reset with every requester valid; requester i adds (100+i)+i
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_op[2*i +: 2]  = 2'b00;
            req_a[64*i +: 64] = 64'(100 + i);
            req_b[64*i +: 64] = 64'(i);
        end
        step();
        step();
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_count", 64'(op_count), 64'd0);
        chk("rst_id", 64'(rsp_id), 64'd0);
        chk("rst_data", rsp_data, 64'd0);

        // Round-robin fairness with all requesters valid
        rst_n = 1'b1;
        ng = 0;
        nr = 0;
        for (int i = 0; i < 8; i++) begin
            gid[i] = -1; gcyc[i] = -1; rid[i] = -1; rdat[i] = '0;
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            #1;
            if (req_ready != 0) begin
                chk($sformatf("rr_onehot_c%0d", cyc), 64'($onehot(req_ready)), 64'd1);
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_ready[i] && ng < 8) begin
                        gid[ng] = i;
                        gcyc[ng] = cyc;
                    end
                end
                if (ng < 8) ng++;
            end
            if (rsp_valid && nr < 8) begin
                rid[nr] = int'(rsp_id);
                rdat[nr] = rsp_data;
                nr++;
            end
            step();
        end
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rr_grant%0d", i), 64'(gid[i]), 64'(i % 4));
            chk($sformatf("rr_rsp_id%0d", i), 64'(rid[i]), 64'(i % 4));
            chk($sformatf("rr_rsp_data%0d", i), rdat[i], 64'(100 + 2 * (i % 4)));
            if (i > 0) chk($sformatf("rr_interval%0d", i), 64'(gcyc[i] - gcyc[i-1]), 64'd3);
        end
        req_valid = '0;
        for (int i = 0; i < 8 && busy; i++) step();
        chk("drain_idle", 64'(busy), 64'd0);
        chk("count_after_rr", 64'(op_count), 64'(exp_count()));

        // Table-driven single operations (vector 0 is the basic timing case)
        for (int n = 0; n < 9; n++) begin
            run_vec(n, vecs[n]);
        end
        chk("count_after_vec", 64'(op_count), 64'(exp_count()));

        // Backpressure: requester 1 adds 7+8, response held 3 cycles
        req_valid = 4'b0010;
        req_op[3:2] = 2'b00;
        req_a[127:64] = 64'd7;
        req_b[127:64] = 64'd8;
        step();
        req_valid = '0;
        step();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp_valid%0d", i), 64'(rsp_valid), 64'd1);
            chk($sformatf("bp_id%0d", i), 64'(rsp_id), 64'd1);
            chk($sformatf("bp_data%0d", i), rsp_data, 64'd15);
            chk($sformatf("bp_ready%0d", i), 64'(req_ready), 64'd0);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_hs_valid", 64'(rsp_valid), 64'd1);
        chk("bp_hs_ready", 64'(req_ready), 64'd0);
        step();
        chk("bp_after_valid", 64'(rsp_valid), 64'd0);
        chk("bp_after_busy", 64'(busy), 64'd0);
        // Back in IDLE; pointer moved past requester 1
        chk("bp_after_ready", 64'(req_ready), 64'b0100);
        req_valid = '0;
        step();
        chk("count_after_bp", 64'(op_count), 64'(exp_count()));

        // Reset in EXEC: operation discarded, pointer back to 0
        req_valid = 4'b0010;
        req_op[3:2] = 2'b00;
        req_a[127:64] = 64'd1;
        req_b[127:64] = 64'd1;
        step();
        req_valid = '0;
        chk("mid_in_exec", 64'(busy), 64'd1);
        rst_n = 1'b0;
        step();
        chk("mid_valid", 64'(rsp_valid), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_count", 64'(op_count), 64'd0);
        chk("mid_data", rsp_data, 64'd0);
        rst_n = 1'b1;
        req_valid = 4'b1110;
        #1;
        chk("mid_next_grant", 64'(req_ready), 64'b0010);
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("mid_no_rsp%0d", i), 64'(rsp_valid), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
